// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch buffer.
//   NOP_INSN          : word presented to decode before anything has been fetched
//   DEFAULT_RESET_PC  : default first fetch address
//   fetch_state_e     : fetch sequencer states
//   align_word()      : clears the byte-offset bits of an address
package fetch_pkg;

  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;
  localparam logic [31:0] WORD_STEP        = 32'h0000_0004;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  // Word-align an address by masking off bits [1:0].
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_prefetch_buffer_if.sv
// Bus bundle between the fetch stage, instruction memory, the redirect source
// and the decode stage.
//   imem_req_*     : in-order word requests to instruction memory
//   imem_rsp_*     : in-order response words from instruction memory
//   redirect_*     : taken branch/jump restarting fetch
//   inst_*         : queue head presented to decode with valid/ready
// The master modport is the fetch stage; slave is the surrounding system.
interface fetch_prefetch_buffer_if;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/fetch_prefetch_buffer_sync_fifo.sv
// Registered synchronous FIFO with synchronous clear and a hold register.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : drop all entries (overrides push/pop in the same cycle)
//   push/push_data, pop : write and read strobes; push+pop while full is legal
//   head_data  : current head, or the last head shown while the FIFO is empty
//   empty      : no entries
//   count      : number of entries (0..DEPTH)
module sync_fifo #(
  parameter int              WIDTH      = 64,
  parameter int              DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_DATA = {WIDTH{1'b0}},
  localparam int             PTR_W      = $clog2(DEPTH),
  localparam int             CNT_W      = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] hold_r;
  logic             empty_s;
  logic             full_s;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualified push/pop strobes; a push into a full FIFO only lands if a pop frees the slot.
  always_comb begin
    empty_s   = (count_r == {CNT_W{1'b0}});
    full_s    = (count_r == DEPTH_C);
    do_pop_s  = pop && !empty_s && !clr;
    do_push_s = push && !clr && (!full_s || do_pop_s);
  end

  // Storage array; data only, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Remember whatever head was last visible so the output is stable once empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r <= RESET_DATA;
    end else if (!empty_s) begin
      hold_r <= mem_r[rd_ptr_r];
    end else begin
      hold_r <= hold_r;
    end
  end

  // Head selection: live entry when present, otherwise the held value.
  always_comb begin
    if (empty_s) begin
      head_data = hold_r;
    end else begin
      head_data = mem_r[rd_ptr_r];
    end
  end

  assign empty = empty_s;
  assign count = count_r;

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch stage feeding the core's decode input.
// Owns the fetch PC, issues in-order word requests, tags returning words with
// their PCs, queues them, and presents the head to decode with valid/ready.
// A redirect flushes the queue and squashes responses still in flight.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : fetch_prefetch_buffer_if.master (imem request/response,
//               redirect, decode handshake)
module fetch_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  fetch_prefetch_buffer_if.master bus
);

  localparam int               CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]   LIMIT_C = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [31:0]      BOOT_PC = align_word(RESET_PC);

  fetch_state_e     state_r;
  fetch_state_e     state_nxt_s;
  logic [31:0]      fetch_pc_r;
  logic [31:0]      resp_pc_r;
  logic [CNT_W-1:0] inflight_r;
  logic [CNT_W-1:0] inflight_nxt_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic [CNT_W:0]   credit_sum_s;
  logic             fifo_empty_s;
  logic [63:0]      head_s;
  logic [31:0]      redirect_tgt_s;
  logic             req_valid_s;
  logic             req_fire_s;
  logic             rsp_take_s;
  logic             push_s;
  logic             pop_s;

  // Request/response/queue strobes; a redirect blocks issue, push and pop this cycle.
  always_comb begin
    redirect_tgt_s = align_word(bus.redirect_pc);
    credit_sum_s   = {1'b0, inflight_r} + {1'b0, fifo_count_s};
    // Every outstanding request owns a queue slot, so a push can never overflow.
    req_valid_s    = (state_r == RUN) && (credit_sum_s < LIMIT_C) && !bus.redirect_valid;
    req_fire_s     = req_valid_s && bus.imem_req_ready;
    rsp_take_s     = bus.imem_rsp_valid && (inflight_r != CNT_ZERO);
    push_s         = rsp_take_s && (state_r == RUN) && !bus.redirect_valid;
    pop_s          = !fifo_empty_s && bus.inst_ready && !bus.redirect_valid;
  end

  // Outstanding-request count after this edge; squashed responses still retire a credit.
  always_comb begin
    inflight_nxt_s = inflight_r;
    case ({req_fire_s, rsp_take_s})
      2'b10:   inflight_nxt_s = inflight_r + CNT_ONE;
      2'b01:   inflight_nxt_s = inflight_r - CNT_ONE;
      default: inflight_nxt_s = inflight_r;
    endcase
  end

  // Sequencer next state: FLUSH waits for every stale response to drain.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BOOT: begin
        state_nxt_s = RUN;
      end
      RUN: begin
        if (bus.redirect_valid && (inflight_nxt_s != CNT_ZERO)) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH: begin
        if (inflight_nxt_s == CNT_ZERO) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      default: begin
        state_nxt_s = BOOT;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // In-flight request counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r <= CNT_ZERO;
    end else begin
      inflight_r <= inflight_nxt_s;
    end
  end

  // Fetch PC (next address to request) and response PC (tag of next accepted word).
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r <= BOOT_PC;
      resp_pc_r  <= BOOT_PC;
    end else if (bus.redirect_valid) begin
      fetch_pc_r <= redirect_tgt_s;
      resp_pc_r  <= redirect_tgt_s;
    end else begin
      if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + WORD_STEP;
      end
      if (push_s) begin
        resp_pc_r <= resp_pc_r + WORD_STEP;
      end
    end
  end

  sync_fifo #(
    .WIDTH      (64),
    .DEPTH      (DEPTH),
    .RESET_DATA ({BOOT_PC, NOP_INSN})
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.redirect_valid),
    .push      (push_s),
    .push_data ({resp_pc_r, bus.imem_rsp_data}),
    .pop       (pop_s),
    .head_data (head_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = fetch_pc_r;
  assign bus.inst_valid     = !fifo_empty_s;
  assign bus.inst_pc        = head_s[63:32];
  assign bus.inst_data      = head_s[31:0];

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
module tb_fetch_prefetch_buffer;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_prefetch_buffer_if bus_a ();
  fetch_prefetch_buffer_if bus_b ();

  fetch_prefetch_buffer #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  fetch_prefetch_buffer #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        rst;
    logic        rdr;
    logic [31:0] rdr_pc;
    logic        iready;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
    logic [31:0] idata;
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat_a = 1;
  int lat_b = 1;
  int ovf = 0;
  logic rand_ready_a = 1'b0;
  logic rst_seen;

  mreq_t mq_a[$];
  mreq_t mq_b[$];
  logic [31:0] hs_a[$];
  logic [31:0] hs_b[$];
  logic [31:0] pop_pc_a[$];
  logic [31:0] pop_data_a[$];

  logic        a_rv, a_iv, b_rv, b_iv;
  logic [31:0] a_addr, a_ipc, a_idata, b_addr, b_ipc, b_idata;

  vec_t vt[15];

  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // One clock: sample at negedge, run memory models after the rising edge.
  task automatic tick();
    @(negedge clk);
    rst_seen = rst;
    a_rv = bus_a.imem_req_valid; a_addr = bus_a.imem_req_addr; a_iv = bus_a.inst_valid;
    a_ipc = bus_a.inst_pc; a_idata = bus_a.inst_data;
    b_rv = bus_b.imem_req_valid; b_addr = bus_b.imem_req_addr; b_iv = bus_b.inst_valid;
    b_ipc = bus_b.inst_pc; b_idata = bus_b.inst_data;
    if (!rst) begin
      if (bus_a.imem_req_valid && bus_a.imem_req_ready) begin
        hs_a.push_back(bus_a.imem_req_addr);
        mq_a.push_back('{bus_a.imem_req_addr, cyc + lat_a});
      end
      if (bus_b.imem_req_valid && bus_b.imem_req_ready) begin
        hs_b.push_back(bus_b.imem_req_addr);
        mq_b.push_back('{bus_b.imem_req_addr, cyc + lat_b});
      end
      if (bus_a.inst_valid && bus_a.inst_ready && !bus_a.redirect_valid) begin
        pop_pc_a.push_back(bus_a.inst_pc);
        pop_data_a.push_back(bus_a.inst_data);
      end
      if (dut_a.push_s && !dut_a.pop_s && (dut_a.fifo_count_s == 3'd4)) ovf++;
      if (dut_b.push_s && !dut_b.pop_s && (dut_b.fifo_count_s == 3'd4)) ovf++;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rst_seen) begin
      mq_a.delete();
      mq_b.delete();
    end
    if (mq_a.size() > 0 && mq_a[0].due <= cyc) begin
      bus_a.imem_rsp_valid = 1'b1; bus_a.imem_rsp_data = mw(mq_a[0].addr); void'(mq_a.pop_front());
    end else begin
      bus_a.imem_rsp_valid = 1'b0; bus_a.imem_rsp_data = 32'hDEAD_BEEF;
    end
    if (mq_b.size() > 0 && mq_b[0].due <= cyc) begin
      bus_b.imem_rsp_valid = 1'b1; bus_b.imem_rsp_data = mw(mq_b[0].addr); void'(mq_b.pop_front());
    end else begin
      bus_b.imem_rsp_valid = 1'b0; bus_b.imem_rsp_data = 32'hDEAD_BEEF;
    end
    if (rand_ready_a) bus_a.imem_req_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Redirect with two requests in flight, optionally re-targeted during FLUSH.
  task automatic redirect_case(input int id, input logic [31:0] pc1, input logic two,
                               input logic [31:0] pc2, input logic [31:0] exp_start,
                               input int exp_flush);
    int n;
    lat_a = 3;
    bus_a.inst_ready = 1'b1;
    bus_a.imem_req_ready = 1'b1;
    do_reset();
    hs_a.delete();
    n = 0;
    while (hs_a.size() < 2 && n < 20) begin tick(); n++; end
    check("rd_two_issued", id, hs_a.size(), 2);
    hs_a.delete();
    pop_pc_a.delete(); pop_data_a.delete();
    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_pc = pc1;
    tick();
    check("rd_no_req_on_redirect", id, a_rv, 0);
    if (two) begin
      bus_a.redirect_pc = pc2;
      tick();
      check("rd_flush_no_req", id, a_rv, 0);
    end
    bus_a.redirect_valid = 1'b0;
    tick();
    check("rd_queue_empty", id, a_iv, 0);
    n = 1;
    while (!a_rv && n < 20) begin tick(); n++; end
    check("rd_flush_cycles", id, n - 1, exp_flush);
    check("rd_first_addr", id, a_addr, exp_start);
    n = 0;
    while (pop_pc_a.size() < 1 && n < 30) begin tick(); n++; end
    check("rd_first_pop_pc", id, (pop_pc_a.size() > 0) ? pop_pc_a[0] : 32'hFFFF_FFFF, exp_start);
    check("rd_first_pop_data", id, (pop_data_a.size() > 0) ? pop_data_a[0] : 32'hFFFF_FFFF, mw(exp_start));
  endtask

  initial begin
    int n;
    // Cycle table: rst, redirect, redirect_pc, inst_ready, expected req_valid/addr, inst_valid/pc/data.
    vt[0] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, NOP_INSN};
    vt[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, NOP_INSN};
    vt[2] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, NOP_INSN};
    vt[3] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, NOP_INSN};
    for (int k = 0; k < 6; k++) begin
      vt[4 + k] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'(8 + 4 * k), 1'b1, 32'(4 * k), mw(32'(4 * k))};
    end
    vt[10] = '{1'b0, 1'b1, 32'h42, 1'b1, 1'b0, 32'h20, 1'b1, 32'h18, mw(32'h18)};
    vt[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 1'b0, 32'h18, mw(32'h18)};
    vt[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h44, 1'b0, 32'h18, mw(32'h18)};
    vt[13] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h48, 1'b1, 32'h40, mw(32'h40)};
    vt[14] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h4C, 1'b1, 32'h44, mw(32'h44)};

    rst = 1'b1;
    bus_a.imem_req_ready = 1'b1; bus_a.imem_rsp_valid = 1'b0; bus_a.imem_rsp_data = 32'h0;
    bus_a.redirect_valid = 1'b0; bus_a.redirect_pc = 32'h0; bus_a.inst_ready = 1'b1;
    bus_b.imem_req_ready = 1'b1; bus_b.imem_rsp_valid = 1'b0; bus_b.imem_rsp_data = 32'h0;
    bus_b.redirect_valid = 1'b0; bus_b.redirect_pc = 32'h0; bus_b.inst_ready = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      rst = vt[i].rst;
      bus_a.redirect_valid = vt[i].rdr;
      bus_a.redirect_pc = vt[i].rdr_pc;
      bus_a.inst_ready = vt[i].iready;
      tick();
      check("vec_req_valid", i, a_rv, vt[i].rv);
      check("vec_req_addr", i, a_addr, vt[i].addr);
      check("vec_inst_valid", i, a_iv, vt[i].iv);
      check("vec_inst_pc", i, a_ipc, vt[i].ipc);
      check("vec_inst_data", i, a_idata, vt[i].idata);
    end
    bus_a.redirect_valid = 1'b0;

    // Decode stall: credits cap the requests at DEPTH, head holds.
    bus_a.inst_ready = 1'b0;
    do_reset();
    hs_a.delete();
    repeat (20) tick();
    check("stall_issued", 0, hs_a.size(), 4);
    for (int i = 0; i < 4; i++) check("stall_addr", i, (hs_a.size() > i) ? hs_a[i] : 32'hFFFF_FFFF, 32'(4 * i));
    check("stall_req_low", 0, a_rv, 0);
    check("stall_head_valid", 0, a_iv, 1);
    check("stall_head_pc", 0, a_ipc, 32'h0);
    pop_pc_a.delete(); pop_data_a.delete();
    bus_a.inst_ready = 1'b1;
    n = 0;
    while (pop_pc_a.size() < 5 && n < 50) begin tick(); n++; end
    check("stall_pops", 0, pop_pc_a.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check("stall_pop_pc", i, (pop_pc_a.size() > i) ? pop_pc_a[i] : 32'hFFFF_FFFF, 32'(4 * i));
      check("stall_pop_data", i, (pop_data_a.size() > i) ? pop_data_a[i] : 32'hFFFF_FFFF, mw(32'(4 * i)));
    end

    // Redirect with responses in flight, then a second redirect during FLUSH.
    redirect_case(0, 32'h104, 1'b0, 32'h0, 32'h104, 2);
    redirect_case(1, 32'h100, 1'b1, 32'h203, 32'h200, 1);

    // Random memory back-pressure and decode stalls; stream must stay sequential.
    lat_a = 2;
    rand_ready_a = 1'b1;
    do_reset();
    pop_pc_a.delete(); pop_data_a.delete();
    repeat (300) begin
      bus_a.inst_ready = 1'($urandom_range(0, 1));
      tick();
    end
    rand_ready_a = 1'b0;
    bus_a.imem_req_ready = 1'b1;
    bus_a.inst_ready = 1'b1;
    check("rand_progress", 0, (pop_pc_a.size() > 20) ? 32'd1 : 32'd0, 32'd1);
    n = 0;
    for (int i = 0; i < pop_pc_a.size(); i++) begin
      if (pop_pc_a[i] !== 32'(4 * i) || pop_data_a[i] !== mw(32'(4 * i))) n++;
    end
    check("rand_stream_errors", 0, n, 0);

    // High reset PC: address wrap, then reset with three requests in flight.
    lat_b = 3;
    do_reset();
    hs_b.delete();
    n = 0;
    while (hs_b.size() < 3 && n < 20) begin tick(); n++; end
    check("wrap_addr", 0, (hs_b.size() > 0) ? hs_b[0] : 32'h1, 32'hFFFF_FFF8);
    check("wrap_addr", 1, (hs_b.size() > 1) ? hs_b[1] : 32'h1, 32'hFFFF_FFFC);
    check("wrap_addr", 2, (hs_b.size() > 2) ? hs_b[2] : 32'h1, 32'h0000_0000);
    check("mid_rst_inflight", 0, dut_b.inflight_r, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("mid_rst_req_valid", 0, b_rv, 0);
    check("mid_rst_req_addr", 0, b_addr, 32'hFFFF_FFF8);
    check("mid_rst_inst_valid", 0, b_iv, 0);
    check("mid_rst_inst_pc", 0, b_ipc, 32'hFFFF_FFF8);
    check("mid_rst_inst_data", 0, b_idata, NOP_INSN);
    hs_b.delete();
    n = 0;
    while (hs_b.size() < 1 && n < 20) begin tick(); n++; end
    check("mid_rst_restart_addr", 0, (hs_b.size() > 0) ? hs_b[0] : 32'h1, 32'hFFFF_FFF8);

    check("queue_overflow_events", 0, ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
